stream_demux1_to_4: RTL and testbench
=====================================

Name: stream_demux1_to_4

Overview:
- Registered 1-to-4 stream demultiplexer: the write-side counterpart of the 4:1 select mux.
- Accepts one beat on a valid/ready input stream and routes it by a 2-bit select to one of four valid/ready output streams.
- Each output has a one-entry holding register, so a stalled output blocks only beats addressed to it.
- Sits between a single producer and four independent consumers in the datapath.

Parameters:
DW, 8, data width of one beat in bits.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
s_valid  input  1  input beat valid.
s_ready  output  1  input beat accepted when s_valid & s_ready at clk edge.
s_sel  input  2  destination index (0..3), sampled with s_data.
s_data  input  DW  input beat payload.
m_valid  output  4  bit i: output i holds a valid beat.
m_ready  input  4  bit i: consumer i accepts beat when m_valid[i] & m_ready[i].
m_data  output  4*DW  slice [i*DW +: DW] is output i payload.

Behaviour:
- Reset (rst_n low, asynchronous, any time): m_valid = 4'b0000 and m_data = all zeros. In-flight beats are discarded. Outputs stay in this state until the first clk edge after rst_n rises.
- Per output i, the holding register is free when (m_valid[i] == 0) | m_ready[i].
- s_ready is combinational: s_ready = free[s_sel]. No dependency on s_valid.
- Accept: s_valid & s_ready. At the clk edge, reg[s_sel] <= s_data and m_valid[s_sel] <= 1.
- Latency: a beat accepted at edge N appears on m_data slice s_sel with m_valid set after edge N (1 cycle).
- Drain: if m_valid[i] & m_ready[i] and no new beat targets i, then m_valid[i] <= 0. m_data slice i holds its last value (not cleared).
- Simultaneous drain and load on the same output: the new beat replaces the old one, m_valid[i] stays 1. This gives full throughput of 1 beat/cycle per output.
- Independence: outputs not addressed by the current input beat update only by their own drain rule. Loads and drains on different outputs in the same cycle are all honoured.
- Blocking: if s_sel points at a full, stalled output, s_ready = 0. The producer must hold s_valid, s_sel and s_data stable until accepted. Beats to other outputs wait behind it, because ordering is strict.
- m_valid[i] must not drop without a handshake. m_data slice i must be stable while m_valid[i] & ~m_ready[i].
- At most one m_valid bit is newly set per cycle.
- s_sel is always 0..3; there is no default/invalid route.

Optional Feature:
Macro DEMUX_CNT_EN.
- Defined: adds ports cnt_clr (input, 1) and cnt (output, 64 = four 16-bit counters; slice [i*16 +: 16] is output i).
- Counter i increments on each accepted input beat with s_sel == i and wraps 0xFFFF -> 0x0000.
- cnt_clr is synchronous and clears all four counters. When clear and increment coincide, clear wins and the result is 0.
- Counters reset to 0 on rst_n.
- Not defined: ports and counters are absent; datapath behaviour is identical.

Test Plan:
- Reset: assert rst_n=0 mid-traffic with m_valid=4'b0101 -> m_valid=0 and m_data=0 immediately, with no clk edge.
- Routing: m_ready=4'hF; send s_data 0xA0,0xA1,0xA2,0xA3 with s_sel 0,1,2,3 back-to-back -> each appears on its slice one cycle after acceptance; s_ready stays 1 throughout; 4 beats take 4 cycles.
- Stall/blocking: m_ready[2]=0; send 0x11 to sel 2, then 0x22 to sel 2 -> second beat sees s_ready=0 and waits. Raising m_ready[2] for one cycle -> 0x11 drained and 0x22 loaded on the same edge; m_valid[2] stays 1.
- Independence: output 2 is full and stalled; deliver a beat to sel 1 with m_ready[1]=1 -> accepted, and output 2 data 0x11 is unchanged.
- Same-output throughput: m_ready[3]=1; stream 8 beats 0x30..0x37 to sel 3 -> one beat per cycle, in order, none lost or duplicated.
- DEMUX_CNT_EN: send 3 beats to sel 0 and 1 beat to sel 3 -> cnt slices read 3,0,0,1. Preload counter 0 to 0xFFFF and send 1 beat -> 0x0000. Assert cnt_clr together with an accepted beat -> 0.

Source files
------------

// File: rtl/stream_demux1_to_4.sv
// Registered 1-to-4 valid/ready stream demultiplexer; each output has a one-entry holding register.
// Define DEMUX_CNT_EN to add per-output accepted-beat counters (cnt_clr / cnt ports).
module stream_demux1_to_4 #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [1:0]      s_sel,
  input  logic [DW-1:0]   s_data,
  output logic [3:0]      m_valid,
  input  logic [3:0]      m_ready,
  output logic [4*DW-1:0] m_data
`ifdef DEMUX_CNT_EN
  ,
  input  logic            cnt_clr,
  output logic [63:0]     cnt
`endif
);

  logic [3:0] w_free;
  logic [3:0] w_load;
  logic       w_accept;

  // Ready depends only on the addressed output, never on s_valid.
  assign s_ready  = w_free[s_sel];
  assign w_accept = s_valid & s_ready;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_out
      logic          r_valid;
      logic [DW-1:0] r_data;

      assign w_free[gi] = ~r_valid | m_ready[gi];
      assign w_load[gi] = w_accept & (s_sel == 2'(gi));

      // Load wins over drain, so a draining slot is refilled on the same edge.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_valid <= 1'b0;
          r_data  <= '0;
        end else if (w_load[gi]) begin
          r_valid <= 1'b1;
          r_data  <= s_data;
        end else if (m_ready[gi]) begin
          r_valid <= 1'b0;
        end
      end

      assign m_valid[gi]          = r_valid;
      assign m_data[gi*DW +: DW]  = r_data;

`ifdef DEMUX_CNT_EN
      logic [15:0] r_cnt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= '0;
        end else if (cnt_clr) begin
          r_cnt <= '0;
        end else if (w_load[gi]) begin
          r_cnt <= r_cnt + 16'd1;
        end
      end

      assign cnt[gi*16 +: 16] = r_cnt;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_stream_demux1_to_4.sv
// Self-checking bench for stream_demux1_to_4: directed scenarios plus random traffic
// checked against a per-output queue model of the stream.
module tb_stream_demux1_to_4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [1:0]      s_sel = 2'd0;
  logic [DW-1:0]   s_data = '0;
  logic [3:0]      m_valid;
  logic [3:0]      m_ready = 4'h0;
  logic [4*DW-1:0] m_data;
`ifdef DEMUX_CNT_EN
  logic            cnt_clr = 1'b0;
  logic [63:0]     cnt;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  // Model: beats accepted but not yet consumed, per output, in order.
  logic [DW-1:0] sb_q [4][$];
  logic [DW-1:0] last_data [4];
  int unsigned   beat_cnt [4];

  always #5 clk = ~clk;

  stream_demux1_to_4 #(.DW(DW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_sel   (s_sel),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data)
`ifdef DEMUX_CNT_EN
    ,
    .cnt_clr (cnt_clr),
    .cnt     (cnt)
`endif
  );

  function automatic void model_clear();
    for (int i = 0; i < 4; i++) begin
      sb_q[i].delete();
      last_data[i] = '0;
      beat_cnt[i]  = 0;
    end
  endfunction

  // One clock cycle: compare outputs against the model mid-cycle, then advance the model.
  task automatic step(output logic acc);
    logic          exp_ready;
    logic          exp_v;
    logic [DW-1:0] exp_d;
    @(negedge clk);
    exp_ready = (sb_q[s_sel].size() == 0) || m_ready[s_sel];
    tests_run++;
    if (s_ready !== exp_ready) begin
      tests_failed++;
      $display("FAIL s_ready: got %b expected %b (sel %0d)", s_ready, exp_ready, s_sel);
    end
    for (int i = 0; i < 4; i++) begin
      exp_v = sb_q[i].size() != 0;
      exp_d = exp_v ? sb_q[i][0] : last_data[i];
      tests_run++;
      if (m_valid[i] !== exp_v || m_data[i*DW +: DW] !== exp_d) begin
        tests_failed++;
        $display("FAIL out%0d: got v=%b d=%h expected v=%b d=%h", i, m_valid[i],
                 m_data[i*DW +: DW], exp_v, exp_d);
      end
    end
`ifdef DEMUX_CNT_EN
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (cnt[i*16 +: 16] !== 16'(beat_cnt[i])) begin
        tests_failed++;
        $display("FAIL cnt%0d: got %h expected %h", i, cnt[i*16 +: 16], 16'(beat_cnt[i]));
      end
    end
`endif
    acc = s_valid && exp_ready;
    for (int i = 0; i < 4; i++) begin
      if (sb_q[i].size() != 0 && m_ready[i]) last_data[i] = sb_q[i].pop_front();
    end
    if (acc) sb_q[s_sel].push_back(s_data);
`ifdef DEMUX_CNT_EN
    if (cnt_clr) begin
      for (int i = 0; i < 4; i++) beat_cnt[i] = 0;
    end else if (acc) begin
      beat_cnt[s_sel] = (beat_cnt[s_sel] + 1) % 65536;
    end
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] sel, input logic [DW-1:0] data, output logic acc);
    s_valid = 1'b1;
    s_sel   = sel;
    s_data  = data;
    step(acc);
    s_valid = 1'b0;
  endtask

  task automatic apply_reset();
    #3;
    rst_n = 1'b0;
    #1;
    model_clear();
    tests_run++;
    if (m_valid !== 4'b0000 || m_data !== '0) begin
      tests_failed++;
      $display("FAIL async_reset: got v=%b d=%h expected v=0000 d=0", m_valid, m_data);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic acc;
    apply_reset();
    // Build m_valid=0101 with stalled consumers, then reset mid-cycle.
    m_ready = 4'h0;
    send(2'd0, 8'h5C, acc);
    send(2'd2, 8'h7E, acc);
    tests_run++;
    if (m_valid !== 4'b0101) begin
      tests_failed++;
      $display("FAIL reset_setup: got %b expected 0101", m_valid);
    end
    apply_reset();
  endtask

  task automatic test_routing();
    logic acc;
    m_ready = 4'hF;
    for (int k = 0; k < 4; k++) begin
      send(2'(k), 8'hA0 + 8'(k), acc);
      tests_run++;
      if (acc !== 1'b1 || m_valid[k] !== 1'b1 || m_data[k*DW +: DW] !== 8'hA0 + 8'(k)) begin
        tests_failed++;
        $display("FAIL routing%0d: got acc=%b v=%b d=%h expected acc=1 v=1 d=%h", k, acc,
                 m_valid[k], m_data[k*DW +: DW], 8'hA0 + 8'(k));
      end
    end
    step(acc);
  endtask

  task automatic test_stall();
    logic acc;
    m_ready = 4'b1011;
    send(2'd2, 8'h11, acc);
    s_valid = 1'b1;
    s_sel   = 2'd2;
    s_data  = 8'h22;
    for (int k = 0; k < 2; k++) begin
      step(acc);
      tests_run++;
      if (acc !== 1'b0) begin
        tests_failed++;
        $display("FAIL stall_block: got acc=%b expected 0", acc);
      end
    end
    m_ready[2] = 1'b1;
    step(acc);
    m_ready[2] = 1'b0;
    s_valid = 1'b0;
    tests_run++;
    if (acc !== 1'b1 || m_valid[2] !== 1'b1 || m_data[2*DW +: DW] !== 8'h22) begin
      tests_failed++;
      $display("FAIL stall_replace: got acc=%b v=%b d=%h expected acc=1 v=1 d=22", acc,
               m_valid[2], m_data[2*DW +: DW]);
    end
  endtask

  task automatic test_independence();
    logic acc;
    m_ready = 4'b0100;
    send(2'd2, 8'h11, acc);
    m_ready = 4'b0010;
    send(2'd1, 8'h5A, acc);
    tests_run++;
    if (acc !== 1'b1 || m_valid[2] !== 1'b1 || m_data[2*DW +: DW] !== 8'h11
        || m_data[1*DW +: DW] !== 8'h5A) begin
      tests_failed++;
      $display("FAIL independence: got acc=%b v2=%b d2=%h d1=%h expected acc=1 v2=1 d2=11 d1=5a",
               acc, m_valid[2], m_data[2*DW +: DW], m_data[1*DW +: DW]);
    end
    m_ready = 4'hF;
    step(acc);
  endtask

  task automatic test_throughput();
    logic acc;
    int   n_acc = 0;
    m_ready = 4'hF;
    for (int k = 0; k < 8; k++) begin
      send(2'd3, 8'h30 + 8'(k), acc);
      if (acc) n_acc++;
      tests_run++;
      if (m_valid[3] !== 1'b1 || m_data[3*DW +: DW] !== 8'h30 + 8'(k)) begin
        tests_failed++;
        $display("FAIL throughput%0d: got v=%b d=%h expected v=1 d=%h", k, m_valid[3],
                 m_data[3*DW +: DW], 8'h30 + 8'(k));
      end
    end
    tests_run++;
    if (n_acc != 8) begin
      tests_failed++;
      $display("FAIL throughput_count: got %0d accepted expected 8", n_acc);
    end
    step(acc);
  endtask

  task automatic test_random();
    logic acc = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if (acc || !s_valid) begin
        s_valid = $urandom_range(0, 3) != 0;
        s_sel   = 2'($urandom_range(0, 3));
        s_data  = 8'($urandom);
      end
      m_ready = 4'($urandom);
      step(acc);
    end
    s_valid = 1'b0;
    m_ready = 4'hF;
    step(acc);
    step(acc);
  endtask

`ifdef DEMUX_CNT_EN
  task automatic test_counters();
    logic acc;
    apply_reset();
    m_ready = 4'hF;
    for (int k = 0; k < 3; k++) send(2'd0, 8'(k), acc);
    send(2'd3, 8'h99, acc);
    tests_run++;
    if (cnt !== {16'd1, 16'd0, 16'd0, 16'd3}) begin
      tests_failed++;
      $display("FAIL cnt_basic: got %h expected 0001000000000003", cnt);
    end
    cnt_clr = 1'b1;
    step(acc);
    cnt_clr = 1'b0;
    for (int k = 0; k < 65535; k++) send(2'd0, 8'(k), acc);
    tests_run++;
    if (cnt[15:0] !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL cnt_full: got %h expected ffff", cnt[15:0]);
    end
    send(2'd0, 8'h01, acc);
    tests_run++;
    if (cnt[15:0] !== 16'h0000) begin
      tests_failed++;
      $display("FAIL cnt_wrap: got %h expected 0000", cnt[15:0]);
    end
    send(2'd1, 8'h02, acc);
    cnt_clr = 1'b1;
    send(2'd1, 8'h03, acc);
    cnt_clr = 1'b0;
    tests_run++;
    if (acc !== 1'b1 || cnt !== 64'd0) begin
      tests_failed++;
      $display("FAIL cnt_clr_wins: got acc=%b cnt=%h expected acc=1 cnt=0", acc, cnt);
    end
  endtask
`endif

  initial begin
    model_clear();
    #1;
    test_reset();
    test_routing();
    test_stall();
    test_independence();
    test_throughput();
    test_random();
`ifdef DEMUX_CNT_EN
    test_counters();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
